// File: rtl/aq_lsu_amr_wmb_pkg.sv
// Shared definitions for the AMR write-merge buffer: address width, line geometry
// and the buffer state encodings.
package aq_lsu_amr_wmb_pkg;

    localparam int PADDR      = 40;
    localparam int LINE_BYTES = 64;
    localparam int BEAT_BYTES = 16;
    localparam int BEATS      = LINE_BYTES / BEAT_BYTES;

    typedef enum logic [2:0] {
        WMB_IDLE  = 3'b000,
        WMB_MERGE = 3'b001,
        WMB_AW    = 3'b100,
        WMB_W     = 3'b101,
        WMB_RESP  = 3'b110
    } wmb_state_e;

endpackage

// File: rtl/aq_lsu_amr_wmb_if.sv
// Store-in, load-check and BIU write-burst signals of the write-merge buffer.
// The buffer itself uses the slave modport; the dcache/BIU side uses master.
interface aq_lsu_amr_wmb_if;
    import aq_lsu_amr_wmb_pkg::*;

    logic             amr_dc_wa_dis;
    logic             cp0_lsu_sync_req;
    logic             dc_wmb_st_vld;
    logic [PADDR-1:0] dc_wmb_st_addr;
    logic [15:0]      dc_wmb_st_be;
    logic [127:0]     dc_wmb_st_data;
    logic             wmb_dc_st_grnt;
    logic [PADDR-1:0] dc_wmb_ld_addr;
    logic             wmb_dc_ld_hit;
    logic             wmb_biu_aw_vld;
    logic [PADDR-1:0] wmb_biu_aw_addr;
    logic             biu_wmb_aw_rdy;
    logic             wmb_biu_w_vld;
    logic [127:0]     wmb_biu_w_data;
    logic [15:0]      wmb_biu_w_strb;
    logic             wmb_biu_w_last;
    logic             biu_wmb_w_rdy;
    logic             biu_wmb_b_vld;
    logic             wmb_lsu_empty;

    modport master (
        output amr_dc_wa_dis, cp0_lsu_sync_req, dc_wmb_st_vld, dc_wmb_st_addr,
               dc_wmb_st_be, dc_wmb_st_data, dc_wmb_ld_addr, biu_wmb_aw_rdy,
               biu_wmb_w_rdy, biu_wmb_b_vld,
        input  wmb_dc_st_grnt, wmb_dc_ld_hit, wmb_biu_aw_vld, wmb_biu_aw_addr,
               wmb_biu_w_vld, wmb_biu_w_data, wmb_biu_w_strb, wmb_biu_w_last,
               wmb_lsu_empty
    );

    modport slave (
        input  amr_dc_wa_dis, cp0_lsu_sync_req, dc_wmb_st_vld, dc_wmb_st_addr,
               dc_wmb_st_be, dc_wmb_st_data, dc_wmb_ld_addr, biu_wmb_aw_rdy,
               biu_wmb_w_rdy, biu_wmb_b_vld,
        output wmb_dc_st_grnt, wmb_dc_ld_hit, wmb_biu_aw_vld, wmb_biu_aw_addr,
               wmb_biu_w_vld, wmb_biu_w_data, wmb_biu_w_strb, wmb_biu_w_last,
               wmb_lsu_empty
    );

endinterface

// File: rtl/aq_lsu_amr_wmb_line.sv
// 64-byte line storage with per-byte valid mask; reports whether the mask would be
// full after this cycle's write so a completing store can trigger the drain.
module aq_lsu_wmb_line
    import aq_lsu_amr_wmb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    wr_en,
    input  logic                    clr,
    input  logic [1:0]              wr_beat,
    input  logic [BEAT_BYTES-1:0]   wr_be,
    input  logic [BEAT_BYTES*8-1:0] wr_data,
    input  logic [1:0]              rd_beat,
    output logic                    full,
    output logic [BEAT_BYTES*8-1:0] rd_data,
    output logic [BEAT_BYTES-1:0]   rd_strb
);

    logic [LINE_BYTES-1:0]   mask_q;
    logic [LINE_BYTES-1:0]   mask_nxt;
    logic [LINE_BYTES-1:0]   wr_mask;
    logic [BEAT_BYTES*8-1:0] data_q [BEATS];

    // Clear happens before the new enables are merged, so an allocating store keeps its bytes.
    always_comb begin
        wr_mask = '0;
        if (wr_en) wr_mask[{wr_beat, 4'b0000} +: BEAT_BYTES] = wr_be;
        mask_nxt = (clr ? '0 : mask_q) | wr_mask;
    end

    assign full = &mask_nxt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)            mask_q <= '0;
        else if (wr_en || clr) mask_q <= mask_nxt;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BEAT_BYTES; i++) begin
                if (wr_be[i]) data_q[wr_beat][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    assign rd_data = data_q[rd_beat];
    assign rd_strb = mask_q[{rd_beat, 4'b0000} +: BEAT_BYTES];

endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate: the enable is captured while the clock is low so the
// gated clock never glitches.
module gated_clk_cell (
    input  logic clk_in,
    input  logic local_en,
    output logic clk_out
);

    logic en_lat;

    always_latch begin
        if (!clk_in) en_lat = local_en;
    end

    assign clk_out = clk_in & en_lat;

endmodule

// File: rtl/aq_lsu_amr_wmb.sv
// Write-merge buffer for streaming store misses: merges same-line stores into one
// line and drains it to the BIU as a 4-beat write burst.
module aq_lsu_amr_wmb
    import aq_lsu_amr_wmb_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    aq_lsu_amr_wmb_if.slave   wmb_if
);

    wmb_state_e       state_q;
    wmb_state_e       state_nxt;
    logic [1:0]       beat_q;
    logic [5:0]       tmo_q;
    logic [PADDR-7:0] line_q;
    logic             wmb_clk;
    logic             clk_en;
    logic             same_line;
    logic             pre_trig;
    logic             drain;
    logic             grnt_idle;
    logic             grnt;
    logic             line_clr;
    logic             line_full;
    logic [127:0]     rd_data;
    logic [15:0]      rd_strb;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{wmb_if.dc_wmb_st_addr[3:0], wmb_if.dc_wmb_ld_addr[5:0]};

    assign clk_en = (state_q != WMB_IDLE) | wmb_if.dc_wmb_st_vld;

    gated_clk_cell x_wmb_gclk (
        .clk_in   (forever_cpuclk),
        .local_en (clk_en),
        .clk_out  (wmb_clk)
    );

    // A full mask is left out of pre_trig: a completing store must still be granted and merged.
    assign same_line = (wmb_if.dc_wmb_st_addr[PADDR-1:6] == line_q);
    assign pre_trig  = (wmb_if.dc_wmb_st_vld & !same_line) | !wmb_if.amr_dc_wa_dis
                     | wmb_if.cp0_lsu_sync_req | (tmo_q == 6'(TIMEOUT-1));
    assign grnt_idle = wmb_if.dc_wmb_st_vld & wmb_if.amr_dc_wa_dis & (state_q == WMB_IDLE);
    assign grnt      = grnt_idle
                     | (wmb_if.dc_wmb_st_vld & wmb_if.amr_dc_wa_dis & (state_q == WMB_MERGE)
                        & same_line & !pre_trig);
    assign line_clr  = grnt_idle | ((state_q == WMB_RESP) & wmb_if.biu_wmb_b_vld);
    assign drain     = pre_trig | line_full;

    aq_lsu_wmb_line x_line (
        .clk     (wmb_clk),
        .rst_b   (cpurst_b),
        .wr_en   (grnt),
        .clr     (line_clr),
        .wr_beat (wmb_if.dc_wmb_st_addr[5:4]),
        .wr_be   (wmb_if.dc_wmb_st_be),
        .wr_data (wmb_if.dc_wmb_st_data),
        .rd_beat (beat_q),
        .full    (line_full),
        .rd_data (rd_data),
        .rd_strb (rd_strb)
    );

    always_ff @(posedge wmb_clk or negedge cpurst_b) begin
        if (!cpurst_b) state_q <= WMB_IDLE;
        else           state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            WMB_IDLE:  if (grnt_idle) state_nxt = WMB_MERGE;
            WMB_MERGE: if (drain) state_nxt = WMB_AW;
            WMB_AW:    if (wmb_if.biu_wmb_aw_rdy) state_nxt = WMB_W;
            WMB_W:     if (wmb_if.biu_wmb_w_rdy && beat_q == 2'd3) state_nxt = WMB_RESP;
            WMB_RESP:  if (wmb_if.biu_wmb_b_vld) state_nxt = WMB_IDLE;
            default:   state_nxt = WMB_IDLE;
        endcase
    end

    // Idle timeout only advances while merging with no new store; anything else restarts it.
    always_ff @(posedge wmb_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            beat_q <= 2'd0;
            tmo_q  <= 6'd0;
        end else begin
            if (state_q == WMB_AW)                             beat_q <= 2'd0;
            else if (state_q == WMB_W && wmb_if.biu_wmb_w_rdy) beat_q <= beat_q + 2'd1;
            tmo_q <= (state_q == WMB_MERGE && !grnt && !drain) ? tmo_q + 6'd1 : 6'd0;
        end
    end

    always_ff @(posedge wmb_clk) begin
        if (grnt_idle) line_q <= wmb_if.dc_wmb_st_addr[PADDR-1:6];
    end

    always_comb begin
        wmb_if.wmb_biu_aw_vld = (state_q == WMB_AW);
        wmb_if.wmb_biu_w_vld  = (state_q == WMB_W);
        wmb_if.wmb_biu_w_last = (state_q == WMB_W) && (beat_q == 2'd3);
        wmb_if.wmb_lsu_empty  = (state_q == WMB_IDLE);
        wmb_if.wmb_dc_ld_hit  = (state_q != WMB_IDLE)
                              && (wmb_if.dc_wmb_ld_addr[PADDR-1:6] == line_q);
    end

    assign wmb_if.wmb_dc_st_grnt  = grnt;
    assign wmb_if.wmb_biu_aw_addr = {line_q, 6'b000000};
    assign wmb_if.wmb_biu_w_data  = rd_data;
    assign wmb_if.wmb_biu_w_strb  = rd_strb;

endmodule

// File: doc/aq_lsu_amr_wmb.md
Name: aq_lsu_amr_wmb

Overview:
- Write-merge buffer directly downstream of the AMR detector.
- While amr_dc_wa_dis is high, store misses do not allocate in the dcache. Instead they are handed to this block.
- The block merges them into one 64-byte line buffer and drains that line to the BIU as a 4-beat x 128-bit write burst.
- It also reports load-address conflicts and an empty status, used for sync/fence.

Parameters:
- PADDR, 40, physical address width.
- TIMEOUT, 32, idle cycles in MERGE before a forced drain (6-bit counter; legal range 1..63).

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  reset; asynchronous, active-low (already decided)
- amr_dc_wa_dis  in  1  streaming mode active, from the AMR detector
- cp0_lsu_sync_req  in  1  sync/fence; forces a drain
- dc_wmb_st_vld  in  1  store miss presented while amr_dc_wa_dis is high
- dc_wmb_st_addr  in  40  store address; bits [5:4] select the beat
- dc_wmb_st_be  in  16  byte enables within the 16-byte beat
- dc_wmb_st_data  in  128  store data, lane-aligned
- wmb_dc_st_grnt  out  1  store accepted this cycle (combinational)
- dc_wmb_ld_addr  in  40  load address, for conflict check
- wmb_dc_ld_hit  out  1  load line matches a non-empty buffer; load must replay (combinational)
- wmb_biu_aw_vld  out  1  write address valid
- wmb_biu_aw_addr  out  40  line address {line[39:6], 6'b0}
- biu_wmb_aw_rdy  in  1  address accepted
- wmb_biu_w_vld  out  1  write data valid
- wmb_biu_w_data  out  128  beat data
- wmb_biu_w_strb  out  16  beat strobes; all-zero is legal
- wmb_biu_w_last  out  1  asserted on beat 3
- biu_wmb_w_rdy  in  1  beat accepted
- biu_wmb_b_vld  in  1  write response received
- wmb_lsu_empty  out  1  FSM is IDLE

Behaviour:
- State machine states: IDLE, MERGE, AW, W, RESP.
- Reset: state=IDLE; byte mask=0; beat counter=0; timeout counter=0.
- Output values at reset: aw_vld=0, w_vld=0, w_last=0, grnt=0, ld_hit=0, empty=1.
- Data register and line-address register are not reset.
- Grant is given when dc_wmb_st_vld & amr_dc_wa_dis and one of:
  - state IDLE;
  - state MERGE, same line (st_addr[39:6] == line), and no drain trigger this cycle.
- Any other store is not granted; the dcache holds and retries it.
- Grant in IDLE:
  - latch line = st_addr[39:6];
  - clear the mask, then set mask bits [st_addr[5:4]*16 +: 16] from st_be;
  - write the enabled bytes of st_data into the data register;
  - next state MERGE.
- Grant in MERGE:
  - OR the new enables into the mask;
  - overwrite only the enabled bytes (youngest store wins);
  - reset the timeout counter.
- Drain triggers, evaluated in MERGE:
  - mask is all-ones, including a grant that completes the mask this cycle, which merges first;
  - dc_wmb_st_vld with a different line;
  - amr_dc_wa_dis == 0;
  - cp0_lsu_sync_req;
  - timeout counter == TIMEOUT-1.
- On any drain trigger: next state AW. The timeout counter increments each MERGE cycle without a grant.
- AW: hold aw_vld=1 and aw_addr stable until biu_wmb_aw_rdy; then go to W with beat=0.
- W:
  - w_vld=1; w_data and w_strb come from beat[1:0];
  - on w_rdy, beat increments;
  - w_last=1 when beat==3; the w_rdy on beat 3 moves the FSM to RESP.
- RESP: wait for biu_wmb_b_vld, then clear the mask and go to IDLE.
  - No grant is given in the same cycle as b_vld; the first new grant is in the following IDLE cycle.
- wmb_dc_ld_hit = !IDLE & (ld_addr[39:6] == line).
- Simultaneous events:
  - sync_req in IDLE has no effect;
  - sync_req in AW/W/RESP has no effect (drain already in progress);
  - wa_dis falling with a same-line store in the same cycle: no grant, drain.
- Buffer is never written outside IDLE/MERGE.
- Reset mid-burst: everything returns to reset values immediately. The BIU is responsible for abandoning the transaction.

Decomposition:
- Shared lsu package:
  - PADDR;
  - WMB state encodings (IDLE=3'b000, MERGE=3'b001, AW=3'b100, W=3'b101, RESP=3'b110);
  - LINE_BYTES=64, BEAT_BYTES=16.
- One sub-module aq_lsu_wmb_line: 64-byte data plus mask storage.
  - Inputs: beat select, byte enables, data, clear.
  - Outputs: full flag and read-out of the selected beat.
- Clock gating uses the existing gated_clk_cell, enabled when state != IDLE or dc_wmb_st_vld.

Test Plan:
- Four grants to line 0x1000, beats 0..3, each be=16'hFFFF, wa_dis=1 -> AW addr 0x1000 the cycle after the 4th grant; 4 beats with strb FFFF; w_last on beat 3; empty after b_vld.
- One store to 0x2010 be=0x000F, then 32 idle cycles -> drain starts at the timeout; beat1 strb=0x000F; beats 0/2/3 strb=0.
- Store to 0x3000, then store to 0x3040 -> second store not granted; drain of 0x3000; second store granted the cycle after b_vld returns IDLE.
- Two overlapping stores to 0x4000 (data AA.., then 55.. with be=0x00FF) -> beat0 bytes[7:0]=0x55, bytes[15:8]=0xAA.
- Load to 0x5020 while buffer holds line 0x5000 in W state -> ld_hit=1; after b_vld -> ld_hit=0.
- Assert cpurst_b low during the W state beat 2 -> aw_vld=w_vld=0 and empty=1 asynchronously.
